// File: rtl/core_wb_if.sv
// rtl/core_wb_if.sv - mw_* handshake bundle from the memory-access stage into write-back
interface core_wb_if;
  logic        mw_valid;
  logic        mw_ready;
  logic [31:0] mw_reg_data;
  logic [31:0] mw_mem_data;
  logic        mw_mem_data_valid;
  logic [31:0] mw_csr_data;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic        mw_reg_write_sel;
  logic [11:0] mw_csr;
  logic        mw_csr_write;

  modport master (
    output mw_valid, mw_reg_data, mw_mem_data, mw_mem_data_valid, mw_csr_data,
    output mw_rd, mw_reg_write, mw_reg_write_sel, mw_csr, mw_csr_write,
    input  mw_ready
  );

  modport slave (
    input  mw_valid, mw_reg_data, mw_mem_data, mw_mem_data_valid, mw_csr_data,
    input  mw_rd, mw_reg_write, mw_reg_write_sel, mw_csr, mw_csr_write,
    output mw_ready
  );
endinterface

// File: rtl/core_wb.sv
// rtl/core_wb.sv - write-back stage: waits for load data, commits one registered RF/CSR write per instruction
// Optional retired-instruction counter enabled by CORE_WB_INSTRET_EN.
module core_wb (
  input  logic        clk,
  input  logic        rest,
  core_wb_if.slave    mw,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        retire,
  output logic [63:0] instret
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e      state_q, state_d;

  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        hold_reg_write_q, hold_reg_write_d;
  logic        hold_sel_q, hold_sel_d;
  logic [31:0] hold_reg_data_q, hold_reg_data_d;
  logic [11:0] hold_csr_q, hold_csr_d;
  logic        hold_csr_write_q, hold_csr_write_d;
  logic [31:0] hold_csr_data_q, hold_csr_data_d;

  logic        rf_wr_en_q, rf_wr_en_d;
  logic [4:0]  rf_wr_addr_q, rf_wr_addr_d;
  logic [31:0] rf_wr_data_q, rf_wr_data_d;
  logic        csr_wr_en_q, csr_wr_en_d;
  logic [11:0] csr_wr_addr_q, csr_wr_addr_d;
  logic [31:0] csr_wr_data_q, csr_wr_data_d;
  logic        retire_q, retire_d;

  logic        commit;
  logic [4:0]  c_rd;
  logic        c_reg_write;
  logic [31:0] c_data;
  logic [11:0] c_csr;
  logic        c_csr_write;
  logic [31:0] c_csr_data;

  assign mw.mw_ready = (state_q == IDLE);

  always_comb begin
    state_d          = state_q;
    hold_rd_d        = hold_rd_q;
    hold_reg_write_d = hold_reg_write_q;
    hold_sel_d       = hold_sel_q;
    hold_reg_data_d  = hold_reg_data_q;
    hold_csr_d       = hold_csr_q;
    hold_csr_write_d = hold_csr_write_q;
    hold_csr_data_d  = hold_csr_data_q;

    commit      = 1'b0;
    c_rd        = hold_rd_q;
    c_reg_write = hold_reg_write_q;
    c_data      = hold_sel_q ? mw.mw_mem_data : hold_reg_data_q;
    c_csr       = hold_csr_q;
    c_csr_write = hold_csr_write_q;
    c_csr_data  = hold_csr_data_q;

    case (state_q)
      IDLE: begin
        if (mw.mw_valid) begin
          hold_rd_d        = mw.mw_rd;
          hold_reg_write_d = mw.mw_reg_write;
          hold_sel_d       = mw.mw_reg_write_sel;
          hold_reg_data_d  = mw.mw_reg_data;
          hold_csr_d       = mw.mw_csr;
          hold_csr_write_d = mw.mw_csr_write;
          hold_csr_data_d  = mw.mw_csr_data;
          // Loads whose data arrives with the instruction commit without stalling.
          if (!mw.mw_reg_write_sel || mw.mw_mem_data_valid) begin
            commit      = 1'b1;
            c_rd        = mw.mw_rd;
            c_reg_write = mw.mw_reg_write;
            c_data      = mw.mw_reg_write_sel ? mw.mw_mem_data : mw.mw_reg_data;
            c_csr       = mw.mw_csr;
            c_csr_write = mw.mw_csr_write;
            c_csr_data  = mw.mw_csr_data;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mw.mw_mem_data_valid) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    retire_d      = commit;
    rf_wr_en_d    = commit && c_reg_write && (c_rd != 5'd0);
    csr_wr_en_d   = commit && c_csr_write;
    rf_wr_addr_d  = rf_wr_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    csr_wr_addr_d = csr_wr_addr_q;
    csr_wr_data_d = csr_wr_data_q;
    if (commit) begin
      rf_wr_addr_d  = c_rd;
      rf_wr_data_d  = c_data;
      csr_wr_addr_d = c_csr;
      csr_wr_data_d = c_csr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q          <= IDLE;
      hold_rd_q        <= '0;
      hold_reg_write_q <= 1'b0;
      hold_sel_q       <= 1'b0;
      hold_reg_data_q  <= '0;
      hold_csr_q       <= '0;
      hold_csr_write_q <= 1'b0;
      hold_csr_data_q  <= '0;
      rf_wr_en_q       <= 1'b0;
      rf_wr_addr_q     <= '0;
      rf_wr_data_q     <= '0;
      csr_wr_en_q      <= 1'b0;
      csr_wr_addr_q    <= '0;
      csr_wr_data_q    <= '0;
      retire_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      hold_rd_q        <= hold_rd_d;
      hold_reg_write_q <= hold_reg_write_d;
      hold_sel_q       <= hold_sel_d;
      hold_reg_data_q  <= hold_reg_data_d;
      hold_csr_q       <= hold_csr_d;
      hold_csr_write_q <= hold_csr_write_d;
      hold_csr_data_q  <= hold_csr_data_d;
      rf_wr_en_q       <= rf_wr_en_d;
      rf_wr_addr_q     <= rf_wr_addr_d;
      rf_wr_data_q     <= rf_wr_data_d;
      csr_wr_en_q      <= csr_wr_en_d;
      csr_wr_addr_q    <= csr_wr_addr_d;
      csr_wr_data_q    <= csr_wr_data_d;
      retire_q         <= retire_d;
    end
  end

  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_addr  = rf_wr_addr_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign csr_wr_en   = csr_wr_en_q;
  assign csr_wr_addr = csr_wr_addr_q;
  assign csr_wr_data = csr_wr_data_q;
  assign retire      = retire_q;

`ifdef CORE_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Counts the visible retire pulse, so instret lags retire by one cycle.
  always_comb begin
    instret_d = instret_q;
    if (retire_q) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rest) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: doc/core_wb.md
# core_wb

Write-back stage of the five-stage core, directly downstream of the memory-access stage. It accepts one instruction per handshake from the `mw_*` bundle and waits for load data when the instruction is a load. It then commits the result as a single-cycle registered write to the integer register file and/or the CSR file, and flags the retirement. It provides backpressure to the memory-access stage through `mw_ready`.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: core clock.
- `rest` in 1: reset, synchronous, active-high.
- `mw_valid` in 1: an instruction is presented on `mw_*`.
- `mw_ready` out 1: the stage accepts the presented instruction this cycle.
- `mw_reg_data` in 32: ALU result for non-load writes.
- `mw_mem_data` in 32: load data, already aligned and extended by the LSU.
- `mw_mem_data_valid` in 1: `mw_mem_data` is valid this cycle (single-cycle pulse).
- `mw_csr_data` in 32: CSR write value.
- `mw_rd` in 5: destination register.
- `mw_reg_write` in 1: instruction writes `rd`.
- `mw_reg_write_sel` in 1: 1 selects load data, 0 selects `mw_reg_data`.
- `mw_csr` in 12: CSR address.
- `mw_csr_write` in 1: instruction writes a CSR.
- `rf_wr_en` out 1: register-file write strobe.
- `rf_wr_addr` out 5: register-file write address.
- `rf_wr_data` out 32: register-file write data.
- `csr_wr_en` out 1: CSR write strobe.
- `csr_wr_addr` out 12: CSR write address.
- `csr_wr_data` out 32: CSR write data.
- `retire` out 1: one-cycle pulse per committed instruction.
- `instret` out 64: retired-instruction count (see Configuration).

## Operation
- States: IDLE, WAIT_MEM.
- `mw_ready` = (state == IDLE), combinational.
- Accept: a rising edge with `mw_valid && mw_ready`. The stage latches `rd`, `reg_write`, `reg_write_sel`, `reg_data`, `csr`, `csr_write` and `csr_data` into a holding register.
- Non-load accept (`mw_reg_write_sel == 0`): commit on the next cycle. State stays IDLE.
- Load accept (`mw_reg_write_sel == 1`):
  - If `mw_mem_data_valid == 1` in the accept cycle, latch `mw_mem_data` and commit on the next cycle. State stays IDLE.
  - Otherwise go to WAIT_MEM.
- WAIT_MEM: on the first cycle with `mw_mem_data_valid == 1`, latch `mw_mem_data`, commit on the next cycle and return to IDLE. There is no timeout.
- Commit cycle (all outputs registered, high for exactly one cycle):
  - `retire = 1`.
  - `rf_wr_en = reg_write && (rd != 0)`; `rf_wr_addr = rd`; `rf_wr_data` = selected data.
  - `csr_wr_en = csr_write`; `csr_wr_addr = csr`; `csr_wr_data = csr_data`.
  - A single instruction may assert both `rf_wr_en` and `csr_wr_en` in the same cycle.
- Non-commit cycles: all strobes are 0. Address and data outputs hold their last committed values.
- `mw_valid == 0` at an edge: nothing is accepted and no commit follows.
- `mw_mem_data_valid` in IDLE without a load being accepted is ignored.
- Writes to x0 are suppressed (`rf_wr_en = 0`), but `retire` still pulses.

## Timing
- Reset (`rest == 1` at an edge) sets:
  - state = IDLE;
  - `rf_wr_en`, `csr_wr_en` and `retire` = 0;
  - `rf_wr_addr` = 0, `rf_wr_data` = 0;
  - `csr_wr_addr` = 0, `csr_wr_data` = 0;
  - `instret` = 0;
  - holding register cleared.
- `mw_ready` = 1 during reset and in the cycle after reset.
- Reset asserted while in WAIT_MEM discards the pending load with no commit.
- Non-load latency: accept at edge N, commit visible in cycle N..N+1 (outputs change at edge N, are sampled by the register file at edge N+1).
- Load latency: commit is visible one cycle after the cycle in which `mw_mem_data_valid` is sampled high.
- Throughput: 1 instruction/cycle for non-loads and for loads whose data arrives in the accept cycle. Otherwise `mw_ready` is 0 for every cycle spent in WAIT_MEM.
- Upstream contract: the `mw_*` signals hold stable while `mw_ready == 0`.

## Configuration
- `CORE_WB_INSTRET_EN` defined:
  - A 64-bit counter increments by 1 on each `retire` pulse and drives `instret`.
  - The counter wraps from 2^64−1 to 0.
  - Reset clears the counter.
- `CORE_WB_INSTRET_EN` not defined: no counter is synthesized and `instret` is tied to 0.

## Test plan
- Non-load: reset, then accept `rd=5`, `reg_write=1`, `sel=0`, `reg_data=0x12345678` -> next cycle `rf_wr_en=1`, `rf_wr_addr=5`, `rf_wr_data=0x12345678`, `retire=1`. Strobes are 0 the cycle after.
- Load with late data: accept a load with `rd=3`, `mw_mem_data_valid` low, then pulse it 3 cycles later with `mem_data=0xDEADBEEF` -> `mw_ready=0` for those 3 cycles, then `rf_wr_en=1`, `rf_wr_data=0xDEADBEEF` one cycle after the pulse, and `mw_ready=1` again.
- Back-to-back: 4 consecutive non-loads plus 1 load with same-cycle data -> 5 consecutive `retire` pulses with `mw_ready` never low. `instret=5` with `CORE_WB_INSTRET_EN` defined, 0 without it.
- x0 with CSR write: `rd=0`, `reg_write=1`, `csr_write=1`, `csr=0x300`, `csr_data=0x8` -> `rf_wr_en=0`, `csr_wr_en=1`, `csr_wr_addr=0x300`, `csr_wr_data=0x8`, `retire=1`.
- Reset mid-wait: in WAIT_MEM assert `rest` for 1 cycle, then pulse `mw_mem_data_valid` -> no commit, `retire=0`, state IDLE, `mw_ready=1`.
- Counter wrap (with `CORE_WB_INSTRET_EN`): force the counter to 2^64−1, then retire once -> `instret=0`.
